// File: rtl/spi_arb_pkg.sv
// Shared definitions for the SPI master arbiter.
//   state_e  : transaction FSM states
//   GUARD_W  : width of the lead/trail guard counter
//   MAX_REQ  : largest supported requester count
//   rr_pick  : round-robin winner search starting at a pointer
package spi_arb_pkg;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_LEAD  = 3'd1,
      ST_SEND  = 3'd2,
      ST_WAIT  = 3'd3,
      ST_TRAIL = 3'd4,
      ST_DONE  = 3'd5
   } state_e;

   localparam int GUARD_W = 4;
   localparam int MAX_REQ = 8;

   // Returns the first set request at or above ptr, wrapping modulo n.
   // Returns 0 when nothing is requested; callers qualify with an any-request flag.
   function automatic logic [2:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                          input logic [2:0]         ptr,
                                          input int                 n);
      logic [2:0] win;
      logic       found;
      int         idx;
      win   = 3'd0;
      found = 1'b0;
      for (int k = 0; k < MAX_REQ; k++) begin
         if (k < n) begin
            idx = int'(ptr) + k;
            if (idx >= n) begin
               idx = idx - n;
            end else begin
               idx = idx;
            end
            if (!found && req[3'(idx)]) begin
               win   = 3'(idx);
               found = 1'b1;
            end else begin
               found = found;
            end
         end else begin
            found = found;
         end
      end
      return win;
   endfunction

endpackage

// File: rtl/spi_rr_arbiter.sv
// Round-robin arbiter: combinational winner pick plus a registered search pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   req_i      : level requests
//   gnt_en_i   : a grant is taken this cycle when any_o is high
//   any_o      : at least one request is pending
//   win_o      : index of the winning requester
module spi_rr_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ = 4,
   localparam int IDX_W  = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic [NUM_REQ-1:0] req_i,
   input  logic               gnt_en_i,
   output logic               any_o,
   output logic [IDX_W-1:0]   win_o
);

   logic [2:0]         ptr_q;
   logic [2:0]         ptr_d;
   logic [2:0]         pick_s;
   logic [MAX_REQ-1:0] req_pad_s;

   assign req_pad_s = MAX_REQ'(req_i);
   assign pick_s    = rr_pick(req_pad_s, ptr_q, NUM_REQ);
   assign any_o     = |req_i;
   assign win_o     = pick_s[IDX_W-1:0];

   // Next pointer: one past the winner, only when a grant is actually taken.
   always_comb begin
      ptr_d = ptr_q;
      if (gnt_en_i && any_o) begin
         if (pick_s == 3'(NUM_REQ - 1)) begin
            ptr_d = 3'd0;
         end else begin
            ptr_d = pick_s + 3'd1;
         end
      end else begin
         ptr_d = ptr_q;
      end
   end

   // Pointer register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ptr_q <= 3'd0;
      end else begin
         ptr_q <= ptr_d;
      end
   end

endmodule

// File: rtl/spi_master_arbiter.sv
// Shares one SPI byte shifter between NUM_REQ requesters, round-robin.
// A transaction latches the winner's BUFSIZE-byte buffer, asserts its slave
// select, waits SS_LEAD guard cycles, streams bytes through the shifter's
// start/done handshake, waits SS_TRAIL cycles, then pulses done.
//   clk, rst_n : clock, asynchronous active-low reset
//   req        : level request per requester (sampled only while idle)
//   req_data   : requester r byte b at [(r*BUFSIZE+b)*8 +: 8]
//   gnt, ss    : one-hot grant / slave select for the active transaction
//   done       : one-cycle completion pulse to the served requester
//   shf_start  : one-cycle load strobe for shf_byte
//   shf_byte   : byte to shift, held until shf_done
//   shf_done   : shifter finished the current byte
//   busy       : controller is not idle
module spi_master_arbiter
   import spi_arb_pkg::*;
#(
   parameter int NUM_REQ  = 4,
   parameter int BUFSIZE  = 3,
   parameter int SS_LEAD  = 2,
   parameter int SS_TRAIL = 2
) (
   input  logic                         clk,
   input  logic                         rst_n,
   input  logic [NUM_REQ-1:0]           req,
   input  logic [NUM_REQ*BUFSIZE*8-1:0] req_data,
   output logic [NUM_REQ-1:0]           gnt,
   output logic [NUM_REQ-1:0]           done,
   output logic [NUM_REQ-1:0]           ss,
   output logic                         shf_start,
   output logic [7:0]                   shf_byte,
   input  logic                         shf_done,
   output logic                         busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam int BI_W  = (BUFSIZE > 1) ? $clog2(BUFSIZE) : 1;
   localparam logic [BI_W-1:0] LAST_IDX = BI_W'(BUFSIZE - 1);

   state_e                    state_q;
   logic [NUM_REQ-1:0]        gnt_q;
   logic [NUM_REQ-1:0]        done_q;
   logic [NUM_REQ-1:0]        ss_q;
   logic                      shf_start_q;
   logic [7:0]                shf_byte_q;
   logic                      busy_q;
   logic [BI_W-1:0]           byte_idx_q;
   logic [GUARD_W-1:0]        cnt_q;
   logic [BUFSIZE-1:0][7:0]   buf_q;

   logic                      any_s;
   logic [IDX_W-1:0]          win_s;
   logic [NUM_REQ-1:0]        grant_vec_s;
   logic [BI_W-1:0]           next_idx_s;
   logic [BUFSIZE*8-1:0]      slices_s [NUM_REQ];

   for (genvar r = 0; r < NUM_REQ; r++) begin : g_slice
      assign slices_s[r] = req_data[r*BUFSIZE*8 +: BUFSIZE*8];
   end

   spi_rr_arbiter #(
      .NUM_REQ (NUM_REQ)
   ) u_arb (
      .clk      (clk),
      .rst_n    (rst_n),
      .req_i    (req),
      .gnt_en_i (state_q == ST_IDLE),
      .any_o    (any_s),
      .win_o    (win_s)
   );

   assign next_idx_s = byte_idx_q + BI_W'(1);

   // One-hot decode of the arbiter winner.
   always_comb begin
      grant_vec_s        = {NUM_REQ{1'b0}};
      grant_vec_s[win_s] = 1'b1;
   end

   // Transaction FSM; every output is registered alongside the state.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         gnt_q       <= {NUM_REQ{1'b0}};
         done_q      <= {NUM_REQ{1'b0}};
         ss_q        <= {NUM_REQ{1'b0}};
         shf_start_q <= 1'b0;
         shf_byte_q  <= 8'h00;
         busy_q      <= 1'b0;
         byte_idx_q  <= {BI_W{1'b0}};
         cnt_q       <= {GUARD_W{1'b0}};
         buf_q       <= {(BUFSIZE*8){1'b0}};
      end else begin
         // Strobes default low; states that need them re-assert.
         shf_start_q <= 1'b0;
         done_q      <= {NUM_REQ{1'b0}};
         case (state_q)
            ST_IDLE: begin
               byte_idx_q <= {BI_W{1'b0}};
               if (any_s) begin
                  state_q <= ST_LEAD;
                  gnt_q   <= grant_vec_s;
                  ss_q    <= grant_vec_s;
                  busy_q  <= 1'b1;
                  buf_q   <= slices_s[win_s];
                  cnt_q   <= GUARD_W'(SS_LEAD);
               end else begin
                  state_q <= ST_IDLE;
               end
            end
            ST_LEAD: begin
               // A zero count still spends one cycle here.
               if (cnt_q == {GUARD_W{1'b0}}) begin
                  state_q     <= ST_SEND;
                  shf_start_q <= 1'b1;
                  shf_byte_q  <= buf_q[byte_idx_q];
               end else begin
                  cnt_q <= cnt_q - GUARD_W'(1);
               end
            end
            ST_SEND: begin
               state_q <= ST_WAIT;
            end
            ST_WAIT: begin
               if (shf_done) begin
                  if (byte_idx_q == LAST_IDX) begin
                     state_q <= ST_TRAIL;
                     cnt_q   <= GUARD_W'(SS_TRAIL);
                  end else begin
                     byte_idx_q  <= next_idx_s;
                     state_q     <= ST_SEND;
                     shf_start_q <= 1'b1;
                     shf_byte_q  <= buf_q[next_idx_s];
                  end
               end else begin
                  state_q <= ST_WAIT;
               end
            end
            ST_TRAIL: begin
               if (cnt_q == {GUARD_W{1'b0}}) begin
                  state_q <= ST_DONE;
                  ss_q    <= {NUM_REQ{1'b0}};
                  gnt_q   <= {NUM_REQ{1'b0}};
                  done_q  <= gnt_q;
               end else begin
                  cnt_q <= cnt_q - GUARD_W'(1);
               end
            end
            ST_DONE: begin
               state_q    <= ST_IDLE;
               busy_q     <= 1'b0;
               byte_idx_q <= {BI_W{1'b0}};
            end
            default: begin
               state_q <= ST_IDLE;
               ss_q    <= {NUM_REQ{1'b0}};
               gnt_q   <= {NUM_REQ{1'b0}};
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   assign gnt       = gnt_q;
   assign done      = done_q;
   assign ss        = ss_q;
   assign shf_start = shf_start_q;
   assign shf_byte  = shf_byte_q;
   assign busy      = busy_q;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Directed bench for spi_master_arbiter (NUM_REQ=4, BUFSIZE=3, SS_LEAD=2,
// SS_TRAIL=2) with a behavioural shifter answering shf_done after LAT cycles.
module tb_spi_master_arbiter;

   localparam int NR  = 4;
   localparam int BS  = 3;
   localparam int LAT = 16;

   logic             clk = 1'b0;
   logic             rst_n;
   logic [NR-1:0]    req;
   logic [NR*BS*8-1:0] req_data;
   logic [NR-1:0]    gnt;
   logic [NR-1:0]    done;
   logic [NR-1:0]    ss;
   logic             shf_start;
   logic [7:0]       shf_byte;
   logic             shf_done;
   logic             busy;

   logic             model_done;
   logic             spur_done;
   int               mcnt;

   int n_checks    = 0;
   int n_fail      = 0;
   int onehot_viol = 0;
   logic [NR-1:0] ss_prev = 4'b0000;

   assign shf_done = model_done | spur_done;

   always #5 clk = ~clk;

   spi_master_arbiter #(
      .NUM_REQ (NR), .BUFSIZE (BS), .SS_LEAD (2), .SS_TRAIL (2)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .req_data  (req_data),
      .gnt       (gnt),
      .done      (done),
      .ss        (ss),
      .shf_start (shf_start),
      .shf_byte  (shf_byte),
      .shf_done  (shf_done),
      .busy      (busy)
   );

   // Shifter model: sees shf_start just after an edge, raises shf_done LAT edges later.
   initial begin
      model_done = 1'b0;
      mcnt       = 0;
      forever begin
         @(posedge clk);
         #1;
         model_done = 1'b0;
         if (!rst_n) begin
            mcnt = 0;
         end else if (mcnt != 0) begin
            mcnt = mcnt - 1;
            if (mcnt == 0) model_done = 1'b1;
         end else if (shf_start) begin
            mcnt = LAT;
         end
      end
   end

   // Slave select must be one-hot or zero and never hop between requesters.
   always @(negedge clk) begin
      if ((ss & (ss - 4'd1)) != 4'd0) onehot_viol = onehot_viol + 1;
      if (ss_prev != 4'd0 && ss != 4'd0 && ss != ss_prev) onehot_viol = onehot_viol + 1;
      ss_prev = ss;
   end

   typedef struct {
      logic [NR-1:0]      req;
      logic [NR*BS*8-1:0] data;
      logic [NR-1:0]      exp_gnt;
      logic [7:0]         b0, b1, b2;
      bit                 drop;
      bit                 spur;
   } vec_t;

   vec_t vecs[12];

   task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
      n_checks = n_checks + 1;
      if (act !== exp) begin
         n_fail = n_fail + 1;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   // Runs one full transaction from the current negedge and checks it end to end.
   task automatic do_txn(input string tag, input vec_t v);
      int k;
      logic [7:0] expb [BS];
      expb[0] = v.b0; expb[1] = v.b1; expb[2] = v.b2;
      req      = v.req;
      req_data = v.data;
      k = 0;
      do begin @(negedge clk); k++; end while (gnt == 4'b0000 && k < 20);
      check({tag, "_gnt_tmo"}, 96'(k < 20), 96'd1);
      check({tag, "_gnt"}, 96'(gnt), 96'(v.exp_gnt));
      check({tag, "_ss"},  96'(ss),  96'(v.exp_gnt));
      check({tag, "_busy"}, 96'(busy), 96'd1);
      if (v.drop) begin
         req      = 4'b0000;
         req_data = ~v.data;
      end
      if (v.spur) begin
         spur_done = 1'b1;
         @(negedge clk);
         spur_done = 1'b0;
         check({tag, "_spur_nostart"}, 96'(shf_start), 96'd0);
      end
      for (int b = 0; b < BS; b++) begin
         k = 0;
         while (!shf_start && k < 200) begin @(negedge clk); k++; end
         check($sformatf("%s_start%0d_tmo", tag, b), 96'(k < 200), 96'd1);
         check($sformatf("%s_byte%0d", tag, b), 96'(shf_byte), 96'(expb[b]));
         @(negedge clk);
      end
      k = 0;
      while (done == 4'b0000 && k < 200) begin @(negedge clk); k++; end
      check({tag, "_done_tmo"}, 96'(k < 200), 96'd1);
      check({tag, "_done"}, 96'(done), 96'(v.exp_gnt));
      check({tag, "_ss_off"}, 96'(ss), 96'd0);
      @(negedge clk);
      check({tag, "_idle_gap"}, 96'({busy, gnt}), 96'd0);
   endtask

   localparam logic [95:0] DSTD = 96'h42_41_40_32_31_30_22_21_20_12_11_10;

   initial begin
      int k;
      rst_n = 1'b0; req = 4'b0000; req_data = DSTD; spur_done = 1'b0;

      vecs[0]  = '{4'b0100, DSTD, 4'b0100, 8'h30, 8'h31, 8'h32, 1'b0, 1'b1};
      vecs[1]  = '{4'b1001, DSTD, 4'b1000, 8'h40, 8'h41, 8'h42, 1'b0, 1'b0};
      vecs[2]  = '{4'b1001, DSTD, 4'b0001, 8'h10, 8'h11, 8'h12, 1'b0, 1'b0};
      vecs[3]  = '{4'b1000, DSTD, 4'b1000, 8'h40, 8'h41, 8'h42, 1'b1, 1'b0};
      for (int i = 0; i < 8; i++) begin
         vecs[4+i].req  = 4'b1111;
         vecs[4+i].data = DSTD;
         vecs[4+i].drop = 1'b0;
         vecs[4+i].spur = 1'b0;
      end
      vecs[4].exp_gnt = 4'b0001; vecs[4].b0 = 8'h10; vecs[4].b1 = 8'h11; vecs[4].b2 = 8'h12;
      vecs[5].exp_gnt = 4'b0010; vecs[5].b0 = 8'h20; vecs[5].b1 = 8'h21; vecs[5].b2 = 8'h22;
      vecs[6].exp_gnt = 4'b0100; vecs[6].b0 = 8'h30; vecs[6].b1 = 8'h31; vecs[6].b2 = 8'h32;
      vecs[7].exp_gnt = 4'b1000; vecs[7].b0 = 8'h40; vecs[7].b1 = 8'h41; vecs[7].b2 = 8'h42;
      for (int i = 8; i < 12; i++) begin
         vecs[i].exp_gnt = vecs[i-4].exp_gnt;
         vecs[i].b0 = vecs[i-4].b0; vecs[i].b1 = vecs[i-4].b1; vecs[i].b2 = vecs[i-4].b2;
      end

      // Reset state
      repeat (3) @(negedge clk);
      check("rst_outputs", 96'({gnt, done, ss, shf_start, shf_byte, busy}), 96'd0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_idle", 96'({gnt, ss, busy}), 96'd0);

      // Single transfer with exact guard timing
      req = 4'b0010;
      req_data = DSTD;
      req_data[24 +: 8] = 8'hA5;
      req_data[32 +: 8] = 8'h3C;
      req_data[40 +: 8] = 8'hF0;
      @(negedge clk);
      check("st_gnt", 96'(gnt), 96'(4'b0010));
      check("st_ss", 96'(ss), 96'(4'b0010));
      req = 4'b0000;
      k = 0;
      do begin @(negedge clk); k++; end while (!shf_start && k < 10);
      check("st_lead_cycles", 96'(k), 96'd3);
      check("st_byte0", 96'(shf_byte), 96'(8'hA5));
      @(negedge clk);
      k = 0;
      while (!shf_start && k < 40) begin @(negedge clk); k++; end
      check("st_byte1", 96'(shf_byte), 96'(8'h3C));
      @(negedge clk);
      k = 0;
      while (!shf_start && k < 40) begin @(negedge clk); k++; end
      check("st_byte2", 96'(shf_byte), 96'(8'hF0));
      @(negedge clk);
      k = 0;
      while (!shf_done && k < 40) begin @(negedge clk); k++; end
      check("st_done_seen", 96'(k < 40), 96'd1);
      k = 0;
      @(negedge clk);
      while (ss != 4'b0000 && k < 10) begin @(negedge clk); k++; end
      check("st_trail_cycles", 96'(k), 96'd3);
      check("st_done_pulse", 96'(done), 96'(4'b0010));
      @(negedge clk);
      check("st_busy_drop", 96'(busy), 96'd0);

      // Spurious shf_done while idle is ignored
      spur_done = 1'b1;
      @(negedge clk);
      spur_done = 1'b0;
      check("spur_idle", 96'({busy, gnt, shf_start}), 96'd0);

      // Table: pointer wrap, data isolation, spurious done in LEAD, fairness
      for (int i = 0; i < 12; i++) begin
         do_txn($sformatf("v%0d", i), vecs[i]);
      end
      req = 4'b0000;
      repeat (3) @(negedge clk);

      // Reset in WAIT of byte 1
      req = 4'b0100;
      k = 0;
      do begin @(negedge clk); k++; end while (gnt == 4'b0000 && k < 20);
      check("mr_gnt", 96'(gnt), 96'(4'b0100));
      req = 4'b0000;
      for (int b = 0; b < 2; b++) begin
         k = 0;
         while (!shf_start && k < 60) begin @(negedge clk); k++; end
         @(negedge clk);
      end
      check("mr_in_wait", 96'({busy, ss}), 96'({1'b1, 4'b0100}));
      repeat (4) @(negedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("mr_async_drop", 96'({ss, gnt, busy}), 96'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      // Pointer must restart at 0: 1001 picks requester 0, bytes from index 0.
      do_txn("mr_after", '{4'b1001, DSTD, 4'b0001, 8'h10, 8'h11, 8'h12, 1'b0, 1'b0});
      req = 4'b0000;
      repeat (2) @(negedge clk);

      check("ss_onehot", 96'(onehot_viol), 96'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   // Global watchdog.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

endmodule
